// File: rtl/bk_adder_pkg.sv
// Shared constants and the (G,P) pair type for the Brent-Kung prefix-adder slice.
package bk_adder_pkg;

    localparam int BK_WIDTH = 8;
    localparam int BK_SUM_W = BK_WIDTH + 1;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

endpackage

// File: rtl/bk_pg_cell.sv
// Prefix operator cell: (G,P)hi o (G,P)lo. GRAY=1 drops the propagate output.
module bk_pg_cell #(
    parameter bit GRAY = 1'b0
) (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);

    if (GRAY) begin : g_gray
        // Only group generate is consumed downstream; p_lo has no role here.
        logic unused_p_lo;
        assign unused_p_lo = p_lo;
        assign p_out       = 1'b0;
    end else begin : g_black
        assign p_out = p_hi & p_lo;
    end

endmodule

// File: rtl/brent_kung_8b.sv
// 8-bit Brent-Kung adder: combinational 9-bit sum S plus a registered copy S_q.
module brent_kung_8b
    import bk_adder_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   S,
    output logic [WIDTH:0]   S_q
);

    if (WIDTH != 8) begin : g_width_check
        $error("brent_kung_8b: prefix tree is fixed at 8 bits, WIDTH=%0d", WIDTH);
    end

    logic [7:0] g;
    logic [7:0] p;

    assign g = A[7:0] & B[7:0];
    assign p = A[7:0] ^ B[7:0];

    // Black-cell groups whose propagate feeds a later cell as the high operand.
    pg_t pg_32, pg_54, pg_76, pg_74;
    // Prefix generates G[i:0]; with no carry-in these are the carries.
    logic g_10, g_20, g_30, g_40, g_50, g_60, g_70;
    logic [6:0] unused_gray_p;

    // Up-sweep, level 1
    bk_pg_cell #(.GRAY(1'b1)) u_l1_10 (.g_hi(g[1]), .p_hi(p[1]), .g_lo(g[0]), .p_lo(1'b0),
                                       .g_out(g_10), .p_out(unused_gray_p[0]));
    bk_pg_cell #(.GRAY(1'b0)) u_l1_32 (.g_hi(g[3]), .p_hi(p[3]), .g_lo(g[2]), .p_lo(p[2]),
                                       .g_out(pg_32.g), .p_out(pg_32.p));
    bk_pg_cell #(.GRAY(1'b0)) u_l1_54 (.g_hi(g[5]), .p_hi(p[5]), .g_lo(g[4]), .p_lo(p[4]),
                                       .g_out(pg_54.g), .p_out(pg_54.p));
    bk_pg_cell #(.GRAY(1'b0)) u_l1_76 (.g_hi(g[7]), .p_hi(p[7]), .g_lo(g[6]), .p_lo(p[6]),
                                       .g_out(pg_76.g), .p_out(pg_76.p));

    // Up-sweep, levels 2 and 3
    bk_pg_cell #(.GRAY(1'b1)) u_l2_30 (.g_hi(pg_32.g), .p_hi(pg_32.p), .g_lo(g_10), .p_lo(1'b0),
                                       .g_out(g_30), .p_out(unused_gray_p[1]));
    bk_pg_cell #(.GRAY(1'b0)) u_l2_74 (.g_hi(pg_76.g), .p_hi(pg_76.p), .g_lo(pg_54.g), .p_lo(pg_54.p),
                                       .g_out(pg_74.g), .p_out(pg_74.p));
    bk_pg_cell #(.GRAY(1'b1)) u_l3_70 (.g_hi(pg_74.g), .p_hi(pg_74.p), .g_lo(g_30), .p_lo(1'b0),
                                       .g_out(g_70), .p_out(unused_gray_p[2]));

    // Down-sweep, levels 4 and 5
    bk_pg_cell #(.GRAY(1'b1)) u_l4_50 (.g_hi(pg_54.g), .p_hi(pg_54.p), .g_lo(g_30), .p_lo(1'b0),
                                       .g_out(g_50), .p_out(unused_gray_p[3]));
    bk_pg_cell #(.GRAY(1'b1)) u_l5_20 (.g_hi(g[2]), .p_hi(p[2]), .g_lo(g_10), .p_lo(1'b0),
                                       .g_out(g_20), .p_out(unused_gray_p[4]));
    bk_pg_cell #(.GRAY(1'b1)) u_l5_40 (.g_hi(g[4]), .p_hi(p[4]), .g_lo(g_30), .p_lo(1'b0),
                                       .g_out(g_40), .p_out(unused_gray_p[5]));
    bk_pg_cell #(.GRAY(1'b1)) u_l5_60 (.g_hi(g[6]), .p_hi(p[6]), .g_lo(g_50), .p_lo(1'b0),
                                       .g_out(g_60), .p_out(unused_gray_p[6]));

    logic [7:0] c;
    assign c = {g_70, g_60, g_50, g_40, g_30, g_20, g_10, g[0]};

    assign S = {c[7], p[7:1] ^ c[6:0], p[0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S_q <= '0;
        end else begin
            S_q <= S;
        end
    end

endmodule

// File: tb/tb_brent_kung_8b.sv
// Scoreboard bench for brent_kung_8b: directed corners, exhaustive sweep, register/reset.
module tb_brent_kung_8b;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [8:0] S;
    logic [8:0] S_q;

    brent_kung_8b #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .S    (S),
        .S_q  (S_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_reg;
        logic [8:0] exp;
        string      name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    event      sample_ev;
    int        n_checks = 0;
    int        n_pass   = 0;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (%b) expected %0d (%b)", name, got, got, exp, exp);
        end
    endtask

    // Monitor: drains the scoreboard whenever the driver says outputs are valid.
    initial begin
        sb_entry_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, e.is_reg ? S_q : S, e.exp);
            end
        end
    end

    task automatic expect_out(input bit is_reg, input logic [8:0] exp, input string name);
        sb_entry_t e;
        e.is_reg = is_reg;
        e.exp    = exp;
        e.name   = name;
        sb_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic apply_comb(input logic [7:0] a, input logic [7:0] b,
                              input logic [8:0] exp, input string name);
        A = a;
        B = b;
        #1;
        expect_out(1'b0, exp, name);
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 8'd0;
        B     = 8'd0;

        // Synchronous reset: two edges with rst_n low clear the register.
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out(1'b1, 9'd0, "reset_s_q");

        apply_comb(8'd0,   8'd0,   9'd0,   "0+0");
        apply_comb(8'd255, 8'd1,   9'd256, "255+1");
        apply_comb(8'd255, 8'd255, 9'd510, "255+255");
        apply_comb(8'd170, 8'd85,  9'd255, "170+85");
        apply_comb(8'd128, 8'd128, 9'd256, "128+128");
        apply_comb(8'h7F,  8'h01,  9'd128, "7F+01");
        apply_comb(8'hFF,  8'h00,  9'd255, "FF+00");
        apply_comb(8'hFF,  8'h01,  9'd256, "FF+01");
        apply_comb(8'd37,  8'd90,  9'd127, "37+90");
        apply_comb(8'd100, 8'd156, 9'd256, "100+156");

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                apply_comb(8'(a), 8'(b), 9'(a) + 9'(b), $sformatf("exh_%0d+%0d", a, b));
            end
        end

        // Release reset and check one-cycle register latency.
        @(negedge clk);
        rst_n = 1'b1;
        apply_comb(8'd200, 8'd100, 9'd300, "200+100_comb");
        @(posedge clk);
        #1;
        expect_out(1'b1, 9'd300, "200+100_reg");

        // Mid-stream reset clears S_q but leaves S alone.
        @(negedge clk);
        apply_comb(8'd255, 8'd255, 9'd510, "hold_comb");
        @(posedge clk);
        #1;
        expect_out(1'b1, 9'd510, "hold_reg");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_out(1'b1, 9'd0,   "mid_reset_s_q");
        expect_out(1'b0, 9'd510, "mid_reset_s");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_out(1'b1, 9'd510, "post_reset_s_q");

        #2;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
